// File: rtl/bist_stim_ctrl.sv
// BIST harness: LFSR patterns drive the CUT inputs and a 16-bit MISR compacts its outputs.
// FLUSH holds zero stimulus so unreset CUT flops can settle, then RUN applies N_PAT patterns.
module bist_stim_ctrl #(
  parameter int          N_IN      = 4,
  parameter int          N_OUT     = 1,
  parameter int          N_PAT     = 255,
  parameter int          FLUSH_CYC = 8,
  parameter logic [7:0]  LFSR_SEED = 8'h01,
  parameter logic [15:0] GOLDEN    = 16'h0000
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  output logic [N_IN-1:0]  TPG_OUT,
  input  logic [N_OUT-1:0] RESP_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [15:0]      SIGNATURE,
  output logic [15:0]      PAT_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

  localparam logic [15:0] LAST_PAT    = 16'(N_PAT - 1);
  localparam logic [7:0]  LAST_FLUSH  = 8'(FLUSH_CYC - 1);
  localparam state_t      START_STATE = (FLUSH_CYC == 0) ? S_RUN : S_FLUSH;

  state_t          r_state;
  logic [7:0]      r_lfsr;
  logic [15:0]     r_misr;
  logic [15:0]     r_pat_cnt;
  logic [7:0]      r_flush_cnt;
  logic [N_IN-1:0] r_tpg;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  logic [7:0]  w_lfsr_next;
  logic [15:0] w_resp;
  logic [15:0] w_misr_next;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_resp      = 16'(RESP_IN);
  assign w_misr_next = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000) ^ w_resp;

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_misr      <= '0;
      r_pat_cnt   <= '0;
      r_flush_cnt <= '0;
      r_tpg       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (ABORT && r_busy) begin
      // r_busy is high exactly in FLUSH/RUN, so ABORT is a no-op in IDLE/DONE
      r_state     <= S_IDLE;
      r_misr      <= '0;
      r_pat_cnt   <= '0;
      r_flush_cnt <= '0;
      r_tpg       <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state     <= START_STATE;
            r_lfsr      <= LFSR_SEED;
            r_misr      <= '0;
            r_pat_cnt   <= '0;
            r_flush_cnt <= '0;
            r_tpg       <= (FLUSH_CYC == 0) ? LFSR_SEED[N_IN-1:0] : '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == LAST_FLUSH) begin
            r_state <= S_RUN;
            r_tpg   <= r_lfsr[N_IN-1:0];
          end else begin
            r_flush_cnt <= r_flush_cnt + 8'd1;
          end
        end
        S_RUN: begin
          r_misr    <= w_misr_next;
          r_lfsr    <= w_lfsr_next;
          r_pat_cnt <= r_pat_cnt + 16'd1;
          if (r_pat_cnt == LAST_PAT) begin
            // PASS is resolved against the final capture so it is valid the cycle DONE rises
            r_state <= S_DONE;
            r_tpg   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_misr_next == GOLDEN);
          end else begin
            r_tpg <= w_lfsr_next[N_IN-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TPG_OUT   = r_tpg;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign SIGNATURE = r_misr;
  assign PAT_CNT   = r_pat_cnt;

endmodule

// File: doc/bist_stim_ctrl.md
Name: bist_stim_ctrl

Overview:
- Built-in self-test harness for gate-level benchmark netlists such as the ISCAS89 s-series.
- Drives pseudo-random patterns into the netlist's primary inputs from an LFSR test pattern generator.
- Reads the netlist's primary outputs back and compacts them into a MISR signature, then compares against a golden value.
- Sits outside the circuit under test (CUT) on the same CK domain, acting as the stimulus/response end of the CUT's I/O interface.

Parameters:
- N_IN, 4, CUT primary input count; width of TPG_OUT (1..8).
- N_OUT, 1, CUT primary output count; width of RESP_IN (1..16).
- N_PAT, 255, number of RUN cycles (1..65535).
- FLUSH_CYC, 8, cycles of all-zero stimulus before RUN, to settle the CUT's unreset flops (0..255).
- LFSR_SEED, 8'h01, TPG seed; must be nonzero.
- GOLDEN, 16'h0000, expected signature.

Ports:
- CK  in  1  clock; all state updates on posedge.
- RST_N  in  1  reset; synchronous, active-low.
- START  in  1  begin a test; one-cycle pulse or level.
- ABORT  in  1  cancel the test in progress.
- TPG_OUT  out  N_IN  stimulus to CUT inputs.
- RESP_IN  in  N_OUT  CUT outputs, combinational from TPG_OUT and CUT state.
- BUSY  out  1  high in FLUSH or RUN.
- DONE  out  1  high in DONE state.
- PASS  out  1  DONE && SIGNATURE==GOLDEN.
- SIGNATURE  out  16  MISR contents.
- PAT_CNT  out  16  patterns applied so far in the current test.

Behaviour:
- Reset (RST_N=0 at posedge):
  - state=IDLE, LFSR=LFSR_SEED, MISR=0, PAT_CNT=0, flush counter=0.
  - Outputs: TPG_OUT=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0.
  - Reset mid-test discards all progress; the next test needs a fresh START.
- All outputs are registered or decoded from registers. TPG_OUT is 0 outside RUN.
- FSM states:
  - IDLE: START=1 -> FLUSH and reload LFSR, MISR, PAT_CNT and flush counter. If FLUSH_CYC=0, go straight to RUN instead.
  - FLUSH: TPG_OUT=0 and MISR frozen. Stay FLUSH_CYC cycles, then -> RUN.
  - RUN: TPG_OUT=LFSR[N_IN-1:0].
    - Each RUN cycle, RESP_IN is captured into the MISR at the posedge ending that cycle, i.e. the same cycle the pattern is presented.
    - The LFSR advances and PAT_CNT increments on the same edge.
    - When PAT_CNT reaches N_PAT, go -> DONE. TPG_OUT returns to 0 on that edge.
  - DONE: SIGNATURE holds. START=1 restarts exactly as from IDLE, and DONE drops on that edge.
- ABORT=1 in FLUSH or RUN -> IDLE next edge, MISR and PAT_CNT cleared. ABORT has priority over a simultaneous START. ABORT in IDLE or DONE is ignored.
- START while BUSY is ignored.
- LFSR (8-bit Fibonacci, x^8+x^6+x^5+x^4+1):
  - fb = L[7]^L[5]^L[4]^L[3]; next L = {L[6:0], fb}.
  - Period 255; the LFSR never reaches 0.
- MISR (16-bit, poly 16'h1021):
  - next M = ({M[14:0],1'b0} ^ (M[15] ? 16'h1021 : 0)) ^ zero-extended RESP_IN.
- PAT_CNT saturates at N_PAT and holds its value in DONE.

Test Plan:
- Reset, then START with FLUSH_CYC=0 and RESP_IN tied 0 -> TPG_OUT sequence 1,2,4,8,1 on the first 5 RUN cycles. After N_PAT cycles: DONE=1, SIGNATURE=16'h0000, PASS=1.
- N_PAT=2, RESP_IN=1 both RUN cycles -> SIGNATURE=16'h0001 after the first capture and 16'h0003 at DONE. With GOLDEN=0, PASS=0.
- FLUSH_CYC=8 -> BUSY rises the edge after START, TPG_OUT=0 for exactly 8 cycles, then the first pattern is 1. Total BUSY time is 8+N_PAT cycles.
- ABORT asserted in the cycle after PAT_CNT=3, same cycle as a START pulse -> IDLE, PAT_CNT=0, SIGNATURE=0, DONE=0, START ignored.
- RST_N=0 mid-RUN -> all outputs 0 on the next edge. After RST_N=1 the block stays IDLE until START. A following run reproduces the full-length signature.
- Connect the s27 netlist (G0..G3 from TPG_OUT, G17 to RESP_IN), N_PAT=255 -> repeated runs give identical SIGNATURE. GOLDEN set to that value gives PASS=1. Forcing G17 to stuck-at-1 gives PASS=0.
